// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the five-stage core. It arbitrates ID, EX/LS busy and
// WB trap/ebreak events, serialises system instructions, and keeps saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DRAIN_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_stall_req,
  input  logic             id_redirect,
  input  logic [PC_W-1:0]  id_redirect_pc,
  input  logic             id_serial,
  input  logic             ex_busy,
  input  logic             ls_busy,
  input  logic             wb_exc,
  input  logic [PC_W-1:0]  wb_exc_pc,
  input  logic             wb_ebreak,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exls_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exls_flush,
  output logic             lswb_flush,
  output logic             redirect_ena,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] serial_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_DEPTH + 1);

  typedef enum logic [1:0] {StRun, StSerial, StHalt} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] serial_q, serial_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exls_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exls_flush   = 1'b0;
    lswb_flush   = 1'b0;
    redirect_ena = 1'b0;
    redirect_pc  = '0;

    if (!rst) begin
      // Outputs must show reset values while rst is low, regardless of inputs.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exls_flush = 1'b1;
      lswb_flush = 1'b1;
    end else if (state_q == StHalt) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exls_hold  = 1'b1;
      lswb_flush = 1'b1;
    end else if (wb_exc) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exls_flush   = 1'b1;
      lswb_flush   = 1'b1;
      redirect_ena = 1'b1;
      redirect_pc  = wb_exc_pc;
      state_d      = StRun;
      drain_d      = '0;
    end else if (wb_ebreak) begin
      state_d = StHalt;
    end else if (ls_busy) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exls_hold  = 1'b1;
      lswb_flush = 1'b1;
    end else if (ex_busy) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exls_flush = 1'b1;
    end else if (state_q == StSerial) begin
      // Front end stays frozen while the back end drains one stage per free cycle.
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
      drain_d    = drain_q - 1'b1;
      if (drain_q == DW'(1)) begin
        state_d = StRun;
      end
    end else if (id_stall_req) begin
      // Operands are stale, so any redirect computed from them is dropped.
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end else begin
      if (id_redirect) begin
        redirect_ena = 1'b1;
        redirect_pc  = id_redirect_pc;
        ifid_flush   = 1'b1;
      end
      if (id_valid && id_serial) begin
        drain_d = DW'(DRAIN_DEPTH);
        state_d = StSerial;
      end
    end
  end

  assign halted     = (state_q == StHalt);
  assign stall_d    = sat_inc(stall_q, pc_hold && (state_q != StHalt));
  assign flush_d    = sat_inc(flush_q, redirect_ena);
  assign serial_d   = sat_inc(serial_q, state_q == StSerial);
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign serial_cnt = serial_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StRun;
      drain_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      serial_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written corner sequences and
// randomized stimulus against a freeze-depth reference model; a CNT_W=4 twin checks saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] RP    = 32'h8000_0100;
  localparam logic [31:0] EP    = 32'h8000_0004;

  typedef struct {
    logic valid, stall, redir, serial, exb, lsb, exc, ebk;
    logic [31:0] rpc, epc;
  } in_t;

  typedef struct {
    logic [3:0]  hold;   // pc, ifid, idex, exls
    logic [3:0]  flush;  // ifid, idex, exls, lswb
    logic        ren;
    logic [31:0] rpc;
    logic        halt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_stall_req, id_redirect, id_serial, ex_busy, ls_busy, wb_exc, wb_ebreak;
  logic [PC_W-1:0] id_redirect_pc, wb_exc_pc;

  logic pc_hold, ifid_hold, idex_hold, exls_hold;
  logic ifid_flush, idex_flush, exls_flush, lswb_flush, redirect_ena, halted;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0] stall_cnt, flush_cnt, serial_cnt;

  logic s_pc_hold, s_ifid_hold, s_idex_hold, s_exls_hold;
  logic s_ifid_flush, s_idex_flush, s_exls_flush, s_lswb_flush, s_redirect_ena, s_halted;
  logic [PC_W-1:0] s_redirect_pc;
  logic [3:0] s_stall_cnt, s_flush_cnt, s_serial_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: mode 0=run, 1=serial, 2=halt.
  int     m_mode = 0;
  int     m_drain = 0;
  longint m_stall = 0, m_flush = 0, m_serial = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.PC_W(PC_W), .CNT_W(32), .DRAIN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall_req(id_stall_req),
    .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc), .id_serial(id_serial),
    .ex_busy(ex_busy), .ls_busy(ls_busy), .wb_exc(wb_exc), .wb_exc_pc(wb_exc_pc),
    .wb_ebreak(wb_ebreak), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exls_hold(exls_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exls_flush(exls_flush), .lswb_flush(lswb_flush), .redirect_ena(redirect_ena),
    .redirect_pc(redirect_pc), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .serial_cnt(serial_cnt)
  );

  pipe_hazard_ctrl #(.PC_W(PC_W), .CNT_W(4), .DRAIN_DEPTH(DEPTH)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall_req(id_stall_req),
    .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc), .id_serial(id_serial),
    .ex_busy(ex_busy), .ls_busy(ls_busy), .wb_exc(wb_exc), .wb_exc_pc(wb_exc_pc),
    .wb_ebreak(wb_ebreak), .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold),
    .idex_hold(s_idex_hold), .exls_hold(s_exls_hold), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exls_flush(s_exls_flush), .lswb_flush(s_lswb_flush),
    .redirect_ena(s_redirect_ena), .redirect_pc(s_redirect_pc), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .serial_cnt(s_serial_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input longint v);
    return (v > 15) ? 4'hf : v[3:0];
  endfunction

  function automatic vec_t mk(input logic v, st, rd, se, ex, ls, wx, eb,
                              input logic [31:0] rpc, epc,
                              input logic [3:0] h, f, input logic ren,
                              input logic [31:0] erpc, input logic hl);
    vec_t t;
    t.i.valid = v;  t.i.stall = st; t.i.redir = rd; t.i.serial = se;
    t.i.exb = ex;   t.i.lsb = ls;   t.i.exc = wx;   t.i.ebk = eb;
    t.i.rpc = rpc;  t.i.epc = epc;
    t.e.hold = h;   t.e.flush = f;  t.e.ren = ren;  t.e.rpc = erpc; t.e.halt = hl;
    return t;
  endfunction

  task automatic drive(input in_t in);
    id_valid = in.valid;  id_stall_req = in.stall; id_redirect = in.redir;
    id_serial = in.serial; ex_busy = in.exb; ls_busy = in.lsb;
    wb_exc = in.exc; wb_ebreak = in.ebk;
    id_redirect_pc = in.rpc; wb_exc_pc = in.epc;
  endtask

  // Model: each hazard freezes the pipe up to some depth and drops a bubble just behind it.
  task automatic model_eval(input in_t in, output exp_t e, output int nmode, output int ndrain);
    int lvl;
    lvl = 0;
    e.hold = '0; e.flush = '0; e.ren = 1'b0; e.rpc = '0; e.halt = (m_mode == 2);
    nmode = m_mode;
    ndrain = m_drain;
    if (m_mode == 2) begin
      lvl = 4;
    end else if (in.exc) begin
      e.flush = 4'hf; e.ren = 1'b1; e.rpc = in.epc; nmode = 0; ndrain = 0;
    end else if (in.ebk) begin
      nmode = 2;
    end else begin
      if (in.lsb) lvl = 4;
      else if (in.exb) lvl = 3;
      else if (m_mode == 1 || in.stall) lvl = 2;
      if (m_mode == 1 && !in.lsb && !in.exb) begin
        ndrain = m_drain - 1;
        if (ndrain == 0) nmode = 0;
      end
      if (lvl == 0) begin
        if (in.redir) begin
          e.ren = 1'b1; e.rpc = in.rpc; e.flush[3] = 1'b1;
        end
        if (in.valid && in.serial) begin
          nmode = 1; ndrain = DEPTH;
        end
      end
    end
    for (int i = 0; i < lvl; i++) e.hold[3-i] = 1'b1;
    if (lvl > 0) e.flush[4-lvl] = 1'b1;
  endtask

  task automatic cmp_outs(input string nm, input exp_t e);
    check({nm, ".hold"}, {pc_hold, ifid_hold, idex_hold, exls_hold}, e.hold);
    check({nm, ".flush"}, {ifid_flush, idex_flush, exls_flush, lswb_flush}, e.flush);
    check({nm, ".redirect_ena"}, redirect_ena, e.ren);
    check({nm, ".redirect_pc"}, redirect_pc, e.rpc);
    check({nm, ".halted"}, halted, e.halt);
    check({nm, ".small_outs"},
          {s_pc_hold, s_ifid_hold, s_idex_hold, s_exls_hold, s_ifid_flush, s_idex_flush,
           s_exls_flush, s_lswb_flush, s_redirect_ena, s_redirect_pc, s_halted},
          {e.hold, e.flush, e.ren, e.rpc, e.halt});
  endtask

  task automatic cmp_cnts(input string nm);
    check({nm, ".stall_cnt"}, stall_cnt, m_stall[31:0]);
    check({nm, ".flush_cnt"}, flush_cnt, m_flush[31:0]);
    check({nm, ".serial_cnt"}, serial_cnt, m_serial[31:0]);
    check({nm, ".small_cnts"}, {s_stall_cnt, s_flush_cnt, s_serial_cnt},
          {sat4(m_stall), sat4(m_flush), sat4(m_serial)});
  endtask

  // Called shortly after a rising edge; returns shortly after the next rising edge.
  task automatic step(input in_t in, input bit use_tab, input exp_t tab, input string nm);
    exp_t e;
    int   nmode, ndrain;
    drive(in);
    @(negedge clk);
    model_eval(in, e, nmode, ndrain);
    cmp_outs(nm, use_tab ? tab : e);
    cmp_cnts(nm);
    @(posedge clk);
    if (e.hold[3] && m_mode != 2) m_stall++;
    if (e.ren) m_flush++;
    if (m_mode == 1) m_serial++;
    m_mode = nmode;
    m_drain = ndrain;
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0; m_serial = 0;
  endtask

  // Pulses reset between edges and checks the outputs react without waiting for a clock.
  task automatic reset_pulse(input string nm);
    exp_t r;
    r.hold = '0; r.flush = 4'hf; r.ren = 1'b0; r.rpc = '0; r.halt = 1'b0;
    #1 rst = 1'b0;
    #1;
    cmp_outs(nm, r);
    check({nm, ".cnts"}, {stall_cnt, flush_cnt, serial_cnt, s_stall_cnt, s_flush_cnt,
                          s_serial_cnt}, '0);
    #1 rst = 1'b1;
    model_reset();
  endtask

  vec_t tab[$];
  in_t  idle;
  exp_t zero_e;

  initial begin
    idle = '{default: '0};
    zero_e = '{default: '0};
    drive(idle);

    tab.push_back(mk(0,1,1,0,0,0,0,0, RP,0, 4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,1,1,0,0,0,0,0, RP,0, 4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,1,0,0,0,0,0, RP,0, 4'b0000,4'b1000,1,RP,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    for (int k = 0; k < 3; k++)
      tab.push_back(mk(0,0,1,0,1,1,0,0, RP,0, 4'b1111,4'b0001,0,0,0));
    tab.push_back(mk(0,0,1,0,0,0,0,0, RP,0, 4'b0000,4'b1000,1,RP,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    // Serialising instruction with an idle back end: three drain cycles.
    tab.push_back(mk(1,0,0,1,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    for (int k = 0; k < 3; k++)
      tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0, 4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    // Same, with LS busy for two cycles mid-drain.
    tab.push_back(mk(1,0,0,1,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,0,0, 0,0,  4'b1111,4'b0001,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,0,0, 0,0,  4'b1111,4'b0001,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    // Trap during the drain.
    tab.push_back(mk(1,0,0,1,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b1100,4'b0100,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,1,0, 0,EP, 4'b0000,4'b1111,1,EP,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    // Trap beats ebreak; then a real ebreak halts for good.
    tab.push_back(mk(0,0,0,0,0,0,1,1, 0,EP, 4'b0000,4'b1111,1,EP,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b0000,4'b0000,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,1, 0,0,  4'b0000,4'b0000,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0, 0,0,  4'b1111,4'b0001,0,0,1));
    tab.push_back(mk(0,1,1,0,0,0,0,0, RP,0, 4'b1111,4'b0001,0,0,1));
    tab.push_back(mk(0,0,0,0,0,0,1,0, 0,EP, 4'b1111,4'b0001,0,0,1));

    #1 rst = 1'b0;
    #2;
    begin
      exp_t r;
      r.hold = '0; r.flush = 4'hf; r.ren = 1'b0; r.rpc = '0; r.halt = 1'b0;
      cmp_outs("reset", r);
      check("reset.cnts", {stall_cnt, flush_cnt, serial_cnt}, '0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();

    foreach (tab[i]) begin
      step(tab[i].i, 1'b1, tab[i].e, $sformatf("vec%0d", i));
      if (i == 1) check("stall_after_two", stall_cnt, 2);
      if (i == 8) check("flush_after_two_redirects", flush_cnt, 2);
      if (i == 13) check("serial_plain_drain", serial_cnt, 3);
      if (i == 20) check("serial_busy_drain", serial_cnt, 8);
    end
    begin
      longint frozen;
      frozen = m_stall;
      for (int k = 0; k < 4; k++) step(idle, 1'b0, zero_e, "halt_idle");
      check("halt_stall_frozen", stall_cnt, frozen[31:0]);
      check("halt_sticky", halted, 1'b1);
    end

    // Reset mid-SERIAL aborts the drain.
    reset_pulse("rst_halt");
    begin
      in_t ser;
      ser = idle; ser.valid = 1'b1; ser.serial = 1'b1;
      step(ser, 1'b0, zero_e, "ser_issue");
      step(idle, 1'b0, zero_e, "ser_drain");
      reset_pulse("rst_serial");
      step(idle, 1'b1, zero_e, "after_rst_run");
    end

    // Small counter saturates while the wide one keeps counting.
    reset_pulse("rst_sat");
    begin
      in_t st;
      st = idle; st.stall = 1'b1;
      for (int k = 0; k < 20; k++) step(st, 1'b0, zero_e, "sat");
      check("sat_small", s_stall_cnt, 4'hf);
      check("sat_big", stall_cnt, 20);
    end

    for (int k = 0; k < 1500; k++) begin
      in_t r;
      r.valid  = 1'($urandom_range(0, 1));
      r.stall  = ($urandom_range(0, 3) == 0);
      r.redir  = ($urandom_range(0, 2) == 0);
      r.serial = ($urandom_range(0, 2) == 0);
      r.exb    = ($urandom_range(0, 5) == 0);
      r.lsb    = ($urandom_range(0, 6) == 0);
      r.exc    = ($urandom_range(0, 24) == 0);
      r.ebk    = ($urandom_range(0, 79) == 0);
      r.rpc    = $urandom;
      r.epc    = $urandom;
      if (k % 150 == 149) reset_pulse("rnd_rst");
      step(r, 1'b0, zero_e, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
